rc4_stream_xor: RTL and testbench
=================================

# rc4_stream_xor

Keystream consumer for the RC4 core. Requests a keystream block from `rc4_new_design` by driving its `start`, and captures the `NUMS_OF_BYTES`-byte `ckey` word on the rising edge of `done`. It then XORs that block byte-by-byte onto a valid/ready data stream to produce ciphertext, or plaintext, since the operation is symmetric. It sits between the RC4 generator and the byte-wide data path, and re-requests a block whenever the current one is exhausted.

## Interface
Parameters:
- `NUMS_OF_BYTES`, 4: keystream bytes per generator block; must be ≥1.

Ports:
- `clk`  in  1: single clock; all logic on the rising edge.
- `rst`  in  1: reset, asynchronous and active-high.
- `ks_start`  out  1: level request to the generator; connects to the generator's `start`.
- `ks_done`  in  1: generator `done`; only its rising edge is used.
- `ks_data`  in  `NUMS_OF_BYTES*8`: generator `ckey`; byte k is `ks_data[k*8 +: 8]`.
- `in_valid`  in  1: input byte valid.
- `in_ready`  out  1: input byte accepted when `in_valid && in_ready`.
- `in_data`  in  8: input byte.
- `in_last`  in  1: marks the final byte of a message.
- `out_valid`  out  1: output byte valid.
- `out_ready`  in  1: downstream accepts when `out_valid && out_ready`.
- `out_data`  out  8: `in_data ^ keystream byte`.
- `out_last`  out  1: copy of `in_last` for the byte.
- `busy`  out  1: high whenever the state is not IDLE.

## Operation
- States: IDLE, WAIT_KS, STREAM.
- **IDLE**
  - `in_ready`=0.
  - `in_valid`=1 → WAIT_KS, and `ks_start` is registered to 1 on the same edge.
- **WAIT_KS**
  - `ks_start`=1 and `in_ready`=0.
  - A `done_q` register tracks `ks_done`. When `ks_done && !done_q`, the edge does the following:
    - `kbuf` ← `ks_data`
    - `idx` ← 0
    - `ks_start` ← 0
    - state → STREAM
- **STREAM**
  - `in_ready = !out_valid || out_ready`.
  - On accept:
    - `out_data` ← `in_data ^ kbuf[idx*8 +: 8]`
    - `out_last` ← `in_last`
    - `out_valid` ← 1
  - After the accept, exactly one transition applies:
    - `in_last`=1 → IDLE. Residual keystream bytes are discarded; the next message triggers a fresh request.
    - `in_last`=0 and `idx == NUMS_OF_BYTES-1` → WAIT_KS, with `ks_start` ← 1.
    - Otherwise `idx` increments and the state stays STREAM.
- Output register:
  - `out_valid` clears on `out_ready` when there is no simultaneous new accept.
  - While `out_valid && !out_ready`, `out_data` and `out_last` hold stable.
  - The output register keeps draining in every state, including IDLE and WAIT_KS.
- `ks_done` rising edges outside WAIT_KS are ignored, but `done_q` still tracks `ks_done`.
- An edge that is already high on entry to WAIT_KS does not count; a fresh 0→1 transition is required.
- `idx` width is `$clog2(NUMS_OF_BYTES)`, minimum 1. `idx` never exceeds `NUMS_OF_BYTES-1`.

## Timing
- Reset values:
  - `ks_start`=0, `in_ready`=0, `out_valid`=0, `out_data`=0, `out_last`=0, `busy`=0.
  - State=IDLE, `idx`=0, `kbuf`=0, `done_q`=0.
- `rst` asserted mid-operation: everything returns to reset values immediately. In-flight output and buffered keystream are lost.
- `ks_start` rises 1 cycle after `in_valid` is seen in IDLE.
- `in_ready` rises 1 cycle after the `ks_done` rising edge is sampled.
- Input accept to `out_valid`: 1 cycle.
- Throughput: 1 byte/cycle within a block when `out_ready`=1.
- Block refill costs at least 2 cycles plus generator latency.
- Simultaneous output drain and new accept: `out_valid` stays 1 and the data updates; there is no bubble.

## Configuration
- `RC4_XOR_STATS_EN` defined:
  - Adds output port `byte_count` [31:0], reset 0.
  - Increments on every input accept and wraps at 2^32.
  - Adds output `block_count` [15:0], reset 0, which increments on each keystream capture.
- Not defined: neither port exists and the counter logic is absent.
- All other behaviour is identical with or without the macro.

## Structure
- Shared package `rc4_pkg`:
  - State enum `rc4_xor_state_t` (IDLE, WAIT_KS, STREAM).
  - Byte width constant `RC4_BYTE_W` = 8.
  - Function `ks_byte(block, idx)` for byte selection.
- One sub-module, `rc4_ks_buffer`: the `done_q` register, edge detect, `kbuf` capture and byte-select mux. The FSM and output register stay in `rc4_stream_xor`.

## Test plan
- Basic: N=4, `ks_data`=32'h40302010, stream 00,01,02,03 with `in_last` on 03 and `out_ready`=1 → out 10,21,32,43; `out_last` on 43; exactly 1 `ks_start` request; `busy` falls after the last byte.
- Block boundary: 6-byte message AA×6, with `ks_data`=32'h40302010 and then 32'h0000FF11 → out BA,8A,9A,EA,BB,55; `ks_start` re-asserts the cycle after the 4th accept.
- Backpressure: hold `out_ready`=0 for 5 cycles after the first output → `out_data` stays 10; `in_ready`=0; no byte lost after release.
- Early last: `in_last` on the 2nd byte; next message 00 → new `ks_start` and a fresh capture; output equals byte 0 of the new block.
- Edge rules: `ks_done` held high entering WAIT_KS → no capture until it falls and rises again; a pulse in STREAM is ignored.
- Reset mid-stream: `rst` while `out_valid`=1 → all outputs 0 in the same cycle, state IDLE; with STATS, `byte_count`=0.

Source files
------------

// File: rtl/rc4_pkg.sv
// Shared types and helpers for the RC4 keystream XOR datapath.
// Holds the consumer FSM state encoding and keystream byte selection.
package rc4_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_KS = 2'd1,
    STREAM  = 2'd2
  } rc4_xor_state_t;

  localparam int RC4_BYTE_W    = 8;
  localparam int RC4_MAX_BYTES = 32;
  localparam int RC4_KS_MAX_W  = RC4_MAX_BYTES * RC4_BYTE_W;

  // Pick byte idx out of a keystream block (zero-extended to max width).
  function automatic logic [RC4_BYTE_W-1:0] ks_byte(
    input logic [RC4_KS_MAX_W-1:0] blk,
    input logic [7:0]              idx
  );
    return blk[idx*RC4_BYTE_W +: RC4_BYTE_W];
  endfunction

endpackage

// File: rtl/rc4_ks_buffer.sv
// Keystream block buffer: tracks generator done, detects its rising
// edge, captures the block and selects the current keystream byte.
module rc4_ks_buffer
  import rc4_pkg::*;
#(
  parameter int NB = 4,
  parameter int IW = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ks_done_i,
  input  logic [NB*RC4_BYTE_W-1:0] ks_data_i,
  input  logic                     cap_en_i,
  input  logic [IW-1:0]            idx_i,
  output logic                     cap_o,
  output logic [RC4_BYTE_W-1:0]    byte_o
);

  logic                     done_q;
  logic [NB*RC4_BYTE_W-1:0] kbuf_q;

  // A capture needs a fresh 0->1 on done while the FSM is waiting.
  assign cap_o = cap_en_i && ks_done_i && !done_q;

  // done tracks the generator every cycle; block latched on capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_q <= 1'b0;
      kbuf_q <= '0;
    end else begin
      done_q <= ks_done_i;
      if (cap_o) kbuf_q <= ks_data_i;
    end
  end

  assign byte_o = ks_byte(RC4_KS_MAX_W'(kbuf_q), 8'(idx_i));

endmodule

// File: rtl/rc4_stream_xor.sv
// RC4 keystream consumer: requests blocks and XORs them onto a byte stream.
// Optional RC4_XOR_STATS_EN adds byte_count / block_count outputs.
module rc4_stream_xor
  import rc4_pkg::*;
#(
  parameter int NUMS_OF_BYTES = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  output logic                          ks_start,
  input  logic                          ks_done,
  input  logic [NUMS_OF_BYTES*8-1:0]    ks_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [RC4_BYTE_W-1:0]         in_data,
  input  logic                          in_last,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [RC4_BYTE_W-1:0]         out_data,
  output logic                          out_last,
  output logic                          busy
`ifdef RC4_XOR_STATS_EN
  ,
  output logic [31:0]                   byte_count,
  output logic [15:0]                   block_count
`endif
);

  localparam int IW = (NUMS_OF_BYTES > 1) ? $clog2(NUMS_OF_BYTES) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(NUMS_OF_BYTES - 1);

  rc4_xor_state_t state_q, state_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic           ks_start_q, ks_start_d;
  logic           ov_q, ov_d;
  logic [7:0]     od_q, od_d;
  logic           ol_q, ol_d;
  logic           cap;
  logic           accept;
  logic           at_last;
  logic [7:0]     kbyte;

  rc4_ks_buffer #(
    .NB (NUMS_OF_BYTES),
    .IW (IW)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .ks_done_i (ks_done),
    .ks_data_i (ks_data),
    .cap_en_i  (state_q == WAIT_KS),
    .idx_i     (idx_q),
    .cap_o     (cap),
    .byte_o    (kbyte)
  );

  assign accept  = in_valid && in_ready;
  assign at_last = (idx_q == IDX_LAST);

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next state: request, wait for a block, stream until done.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid) state_d = WAIT_KS;
      WAIT_KS: if (cap) state_d = STREAM;
      STREAM: begin
        if (accept) begin
          if (in_last)      state_d = IDLE;
          else if (at_last) state_d = WAIT_KS;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: accept only when streaming and the output slot frees.
  always_comb begin
    in_ready = (state_q == STREAM) && (!ov_q || out_ready);
    busy     = (state_q != IDLE);
  end

  // Request level and byte index follow captures and accepts.
  always_comb begin
    ks_start_d = ks_start_q;
    idx_d      = idx_q;
    if (state_q == IDLE && in_valid) ks_start_d = 1'b1;
    if (cap) begin
      ks_start_d = 1'b0;
      idx_d      = '0;
    end
    if (accept && !in_last) begin
      if (at_last) ks_start_d = 1'b1;
      else         idx_d      = idx_q + 1'b1;
    end
  end

  // Output slot: load on accept, drain on ready, otherwise hold.
  always_comb begin
    ov_d = ov_q;
    od_d = od_q;
    ol_d = ol_q;
    if (accept) begin
      ov_d = 1'b1;
      od_d = in_data ^ kbyte;
      ol_d = in_last;
    end else if (out_ready) begin
      ov_d = 1'b0;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q      <= '0;
      ks_start_q <= 1'b0;
      ov_q       <= 1'b0;
      od_q       <= '0;
      ol_q       <= 1'b0;
    end else begin
      idx_q      <= idx_d;
      ks_start_q <= ks_start_d;
      ov_q       <= ov_d;
      od_q       <= od_d;
      ol_q       <= ol_d;
    end
  end

  assign ks_start  = ks_start_q;
  assign out_valid = ov_q;
  assign out_data  = od_q;
  assign out_last  = ol_q;

`ifdef RC4_XOR_STATS_EN
  logic [31:0] byte_cnt_q;
  logic [15:0] blk_cnt_q;

  // Free-running traffic counters, wrapping naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_cnt_q <= '0;
      blk_cnt_q  <= '0;
    end else begin
      if (accept) byte_cnt_q <= byte_cnt_q + 32'd1;
      if (cap)    blk_cnt_q  <= blk_cnt_q + 16'd1;
    end
  end

  assign byte_count  = byte_cnt_q;
  assign block_count = blk_cnt_q;
`endif

endmodule

// File: tb/tb_rc4_stream_xor.sv
// Bench for rc4_stream_xor: generator model, stream model, directed
// cases with literal expectations, then randomized traffic.
module tb_rc4_stream_xor;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           ks_start;
  logic           ks_done = 1'b0;
  logic [N*8-1:0] ks_data = '0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [7:0]     in_data = '0;
  logic           in_last = 1'b0;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic [7:0]     out_data;
  logic           out_last;
  logic           busy;
`ifdef RC4_XOR_STATS_EN
  logic [31:0]    byte_count;
  logic [15:0]    block_count;
`endif

  always #5 clk = ~clk;

  rc4_stream_xor #(.NUMS_OF_BYTES(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .ks_start  (ks_start),
    .ks_done   (ks_done),
    .ks_data   (ks_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy)
`ifdef RC4_XOR_STATS_EN
    ,
    .byte_count  (byte_count),
    .block_count (block_count)
`endif
  );

  int vecs = 0;
  int errs = 0;

  logic [N*8-1:0] gen_q[$];
  logic [N*8-1:0] preset_q[$];
  logic [7:0]     exp_d_q[$];
  logic           exp_l_q[$];
  logic [7:0]     lit_q[$];
  logic [N*8-1:0] m_blk = '0;
  int             m_pos = N;
  bit             gen_en = 1'b0;
  bit             rand_ordy = 1'b0;
  int             ks_req = 0;
  logic           ks_start_prev = 1'b0;
  int             gen_blocks = 0;
  int             acc_bytes = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Stream model: the n-th accepted byte of a message uses keystream
  // byte n mod N of the block fetched for it; last drops the rest.
  always @(negedge clk) begin
    if (!rst) begin
      if (ks_start && !ks_start_prev) ks_req++;
      ks_start_prev = ks_start;
      if (ks_start) check("in_ready_while_waiting", 32'(in_ready), 0);
      if (in_valid && in_ready) begin
        acc_bytes++;
        if (m_pos == N) begin
          if (gen_q.size() == 0) begin
            check("keystream_available", 0, 1);
            m_blk = '0;
          end else begin
            m_blk = gen_q.pop_front();
          end
          m_pos = 0;
        end
        exp_d_q.push_back(in_data ^ m_blk[m_pos*8 +: 8]);
        exp_l_q.push_back(in_last);
        m_pos++;
        if (in_last) m_pos = N;
      end
      if (out_valid && out_ready) begin
        if (exp_d_q.size() == 0) begin
          check("unexpected_output", 1, 0);
        end else begin
          check("out_data", 32'(out_data), 32'(exp_d_q.pop_front()));
          check("out_last", 32'(out_last), 32'(exp_l_q.pop_front()));
          if (lit_q.size() > 0)
            check("out_literal", 32'(out_data), 32'(lit_q.pop_front()));
        end
      end
    end
  end

  // Generator model: answers each request with one done pulse.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (gen_en && ks_start && !ks_done) begin
        repeat ($urandom_range(0, 4)) begin
          @(posedge clk);
          #1;
        end
        if (preset_q.size() > 0) ks_data = preset_q.pop_front();
        else                     ks_data = (N*8)'($urandom);
        gen_q.push_back(ks_data);
        gen_blocks++;
        ks_done = 1'b1;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
        ks_done = 1'b0;
      end
    end
  end

  // Random downstream backpressure.
  always @(posedge clk) begin
    #1;
    if (rand_ordy) out_ready = ($urandom % 4) != 0;
  end

  task automatic send_byte(input logic [7:0] d, input logic l);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        return;
      end
    end
    check("accept_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (exp_d_q.size() == 0 && !out_valid) return;
    end
    check("drain_timeout", 0, 1);
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ks_start", 32'(ks_start), 0);
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_data", 32'(out_data), 0);
    check("rst_out_last", 32'(out_last), 0);
    check("rst_busy", 32'(busy), 0);
`ifdef RC4_XOR_STATS_EN
    check("rst_byte_count", byte_count, 0);
    check("rst_block_count", 32'(block_count), 0);
`endif
    rst = 1'b0;
    gen_en = 1'b1;
    @(posedge clk);
    #1;

    // Basic single-block message.
    preset_q.push_back(32'h40302010);
    lit_q = '{8'h10, 8'h21, 8'h32, 8'h43};
    ks_req = 0;
    for (int i = 0; i < 4; i++) send_byte(8'(i), i == 3);
    drain();
    check("basic_requests", 32'(ks_req), 1);
    check("basic_busy_after", 32'(busy), 0);

    // Message spanning a block boundary.
    preset_q.push_back(32'h40302010);
    preset_q.push_back(32'h0000FF11);
    lit_q = '{8'hBA, 8'h8A, 8'h9A, 8'hEA, 8'hBB, 8'h55};
    ks_req = 0;
    for (int i = 0; i < 6; i++) begin
      send_byte(8'hAA, i == 5);
      if (i == 3) check("refill_request", 32'(ks_start), 1);
    end
    drain();
    check("boundary_requests", 32'(ks_req), 2);

    // Backpressure after first output.
    preset_q.push_back(32'h40302010);
    lit_q = '{8'h10, 8'h21, 8'h32, 8'h43};
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++) send_byte(8'(i), i == 3);
      end
      begin
        for (int k = 0; k < 300 && !out_valid; k++) @(negedge clk);
        check("bp_first_valid", 32'(out_valid), 1);
        repeat (5) begin
          @(negedge clk);
          check("bp_hold_data", 32'(out_data), 32'h10);
          check("bp_in_ready", 32'(in_ready), 0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Early last discards the rest of the block.
    preset_q.push_back(32'hDDCCBBAA);
    preset_q.push_back(32'h44332211);
    lit_q = '{8'hAF, 8'hBD, 8'h11};
    ks_req = 0;
    send_byte(8'h05, 1'b0);
    send_byte(8'h06, 1'b1);
    send_byte(8'h00, 1'b1);
    drain();
    check("early_last_requests", 32'(ks_req), 2);

    // Edge rules with a hand-driven generator.
    gen_en = 1'b0;
    @(posedge clk);
    #1;
    ks_done = 1'b1;
    ks_data = 32'h87654321;
    lit_q = '{8'h21, 8'h43, 8'h65, 8'h87};
    fork
      send_byte(8'h00, 1'b0);
      begin
        repeat (6) @(posedge clk);
        #1;
        check("stale_done_no_capture", 32'(in_ready), 0);
        check("stale_done_still_req", 32'(ks_start), 1);
        ks_done = 1'b0;
        @(posedge clk);
        #1;
        gen_q.push_back(ks_data);
        gen_blocks++;
        ks_done = 1'b1;
        @(posedge clk);
        #1;
        ks_done = 1'b0;
      end
    join
    @(posedge clk);
    #1;
    ks_data = 32'hFFFFFFFF;
    ks_done = 1'b1;
    @(posedge clk);
    #1;
    ks_done = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 1; i < 4; i++) send_byte(8'h00, i == 3);
    drain();
    gen_en = 1'b1;

    // Randomized messages with random gaps and backpressure.
    rand_ordy = 1'b1;
    for (int m = 0; m < 40; m++) begin
      int len;
      len = $urandom_range(1, 10);
      for (int b = 0; b < len; b++) begin
        send_byte(8'($urandom), b == len - 1);
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk);
          #1;
        end
      end
    end
    drain();
    rand_ordy = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    check("random_idle", 32'(busy), 0);
`ifdef RC4_XOR_STATS_EN
    check("stats_bytes", byte_count, 32'(acc_bytes));
    check("stats_blocks", 32'(block_count), 32'(gen_blocks));
`endif

    // Reset with a byte held in the output slot.
    out_ready = 1'b0;
    send_byte(8'h55, 1'b0);
    check("pre_rst_valid", 32'(out_valid), 1);
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 0);
    check("mid_rst_out_data", 32'(out_data), 0);
    check("mid_rst_out_last", 32'(out_last), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_ks_start", 32'(ks_start), 0);
    check("mid_rst_in_ready", 32'(in_ready), 0);
`ifdef RC4_XOR_STATS_EN
    check("mid_rst_byte_count", byte_count, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end

endmodule
